// File: rtl/valu_pkg.sv
// Shared vALU/VRF constants and the write-back entry type.
package valu_pkg;

   localparam int VRF_DATA_W     = 64;
   localparam int VRF_ADDR_W     = 32;
   localparam int VRF_MASK_W     = VRF_DATA_W / 8;
   localparam int ALU_PIPE_DEPTH = 6;

   typedef struct packed {
      logic [VRF_ADDR_W-1:0] addr;
      logic [VRF_DATA_W-1:0] data;
      logic [VRF_MASK_W-1:0] be;
   } vwb_entry_t;

endpackage

// File: rtl/valu_wb_qmem.sv
// Write-back queue storage: DEPTH entries, one write port, one async read port.
module valu_wb_qmem
   import valu_pkg::*;
#(
   parameter int  DEPTH   = 8,
   parameter type entry_t = vwb_entry_t
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_idx,
   input  entry_t                   wr_entry,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output entry_t                   rd_entry
);

   // Storage is left unreset; the top only presents entries it has written.
   entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_entry;
   end

   assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/valu_wb_queue.sv
// vALU result write-back queue draining to the VRF write port.
// Optional same-cycle empty-queue bypass enabled by defining VALU_WB_BYPASS_EN.
module valu_wb_queue
   import valu_pkg::*;
#(
   parameter int DATA_WIDTH   = VRF_DATA_W,
   parameter int ADDR_WIDTH   = VRF_ADDR_W,
   parameter int MASK_WIDTH   = VRF_MASK_W,
   parameter int DEPTH        = 8,
   parameter int STALL_MARGIN = ALU_PIPE_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [ADDR_WIDTH-1:0]      in_addr,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic [MASK_WIDTH-1:0]      in_be,
   output logic                       wr_valid,
   input  logic                       wr_ready,
   output logic [ADDR_WIDTH-1:0]      wr_addr,
   output logic [DATA_WIDTH-1:0]      wr_data,
   output logic [MASK_WIDTH-1:0]      wr_be,
   output logic                       issue_stall,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [PTR_W-1:0] STALL_LEVEL = PTR_W'(DEPTH - STALL_MARGIN);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [MASK_WIDTH-1:0] be;
   } entry_t;

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] count_q;
   logic [PTR_W-1:0] count_next;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             take_in;
   logic             stall_q;
   logic             err_q;
   entry_t           in_entry;
   entry_t           head;
   entry_t           out_entry;

   assign in_entry = '{addr: in_addr, data: in_data, be: in_be};

   assign empty = (rd_ptr == wr_ptr);
   assign full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) &&
                  (rd_ptr[PTR_W-1] != wr_ptr[PTR_W-1]);

   // pop only ever removes a stored head; a bypassed result never enters storage.
   assign pop = !empty && wr_ready;

`ifdef VALU_WB_BYPASS_EN
   logic bypass;
   assign bypass    = empty && in_valid;
   assign take_in   = in_valid && (!full || pop) && !(bypass && wr_ready);
   assign wr_valid  = !empty || in_valid;
   assign out_entry = bypass ? in_entry : (empty ? '0 : head);
`else
   assign take_in   = in_valid && (!full || pop);
   assign wr_valid  = !empty;
   assign out_entry = empty ? '0 : head;
`endif

   assign push = take_in;

   assign wr_addr = out_entry.addr;
   assign wr_data = out_entry.data;
   assign wr_be   = out_entry.be;

   assign count_next = count_q + PTR_W'(push) - PTR_W'(pop);

   valu_wb_qmem #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_qmem (
      .clk      (clk),
      .wr_en    (push),
      .wr_idx   (wr_ptr[IDX_W-1:0]),
      .wr_entry (in_entry),
      .rd_idx   (rd_ptr[IDX_W-1:0]),
      .rd_entry (head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         stall_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count_q <= count_next;
         stall_q <= (count_next >= STALL_LEVEL);
         // A result arriving into a full queue with no drain this cycle is lost.
         if (in_valid && full && !pop) err_q <= 1'b1;
      end
   end

   assign count        = count_q;
   assign issue_stall  = stall_q;
   assign overflow_err = err_q;

endmodule

// File: tb/tb_valu_wb_queue.sv
// Self-checking bench for valu_wb_queue against a queue-based reference model.
module tb_valu_wb_queue;

   localparam int DEPTH  = 8;
   localparam int MARGIN = 6;
`ifdef VALU_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_addr;
   logic [63:0] in_data;
   logic [7:0]  in_be;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_addr;
   logic [63:0] wr_data;
   logic [7:0]  wr_be;
   logic        issue_stall;
   logic [3:0]  count;
   logic        overflow_err;

   int errors = 0;
   int checks = 0;

   entry_t      q[$];
   logic [31:0] drained[$];
   logic [31:0] pushed[$];
   bit          stall_m;
   bit          ovf_m;

   valu_wb_queue dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_addr      (in_addr),
      .in_data      (in_data),
      .in_be        (in_be),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_be        (wr_be),
      .issue_stall  (issue_stall),
      .count        (count),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
   task automatic step(input bit iv, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] b, input bit rdy);
      entry_t e;
      entry_t exp_e;
      bit     exp_v;
      bit     pop;
      bit     byp_take;
      bit     acc;
      e = '{addr: a, data: d, be: b};
      in_valid = iv; in_addr = a; in_data = d; in_be = b; wr_ready = rdy;
      #3;
      exp_v = (q.size() > 0) || (BYP && iv);
      chk("wr_valid", wr_valid, exp_v);
      if (exp_v) begin
         exp_e = (q.size() > 0) ? q[0] : e;
         chk("wr_fields", {wr_addr, wr_data, wr_be}, exp_e);
      end
      chk("count", count, q.size());
      chk("issue_stall", issue_stall, stall_m);
      chk("overflow_err", overflow_err, ovf_m);
      pop      = (q.size() > 0) && rdy;
      byp_take = BYP && (q.size() == 0) && iv && rdy;
      acc      = iv && (q.size() < DEPTH || pop) && !byp_take;
      if (iv && q.size() == DEPTH && !pop) ovf_m = 1'b1;
      if (pop) drained.push_back(q.pop_front().addr);
      if (byp_take) drained.push_back(a);
      if (acc) q.push_back(e);
      stall_m = (q.size() >= DEPTH - MARGIN);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; wr_ready = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete(); stall_m = 1'b0; ovf_m = 1'b0;
      #3;
      chk("rst_wr_valid", wr_valid, 1'b0);
      chk("rst_count", count, 0);
      chk("rst_issue_stall", issue_stall, 1'b0);
      chk("rst_overflow_err", overflow_err, 1'b0);
      chk("rst_wr_fields", {wr_addr, wr_data, wr_be}, 0);
      @(posedge clk); #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      int          n;
      int          guard;
      bit          rdy;
      bit          iv;
      logic [31:0] a;

      rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; in_be = '0; wr_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Single write followed by idle cycles.
      wr_ready = 1'b1;
      step(1, 32'h40, 64'h1122334455667788, 8'hFF, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("single_count", count, 0);

      // Backpressure: fill, overflow, then drain in order.
      for (int i = 0; i < DEPTH; i++) step(1, i, rnd64(), 8'(i == 3 ? 0 : $urandom), 0);
      chk("bp_count", count, DEPTH);
      chk("bp_stall", issue_stall, 1'b1);
      step(1, 32'h8, rnd64(), 8'hFF, 0);
      chk("bp_overflow", overflow_err, 1'b1);
      step(0, 0, 0, 0, 0);
      drained.delete();
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1);
      chk("bp_drained_n", drained.size(), DEPTH);
      for (int i = 0; i < DEPTH && i < drained.size(); i++) chk("bp_order", drained[i], i);
      step(0, 0, 0, 0, 1);

      // Reset mid-drain with three entries queued.
      for (int i = 0; i < 3; i++) step(1, 32'h20 + i, rnd64(), 8'hF0, 0);
      do_reset();

      // Full queue with simultaneous push and pop.
      for (int i = 0; i < DEPTH; i++) step(1, 32'h10 + i, rnd64(), 8'h0F, 0);
      drained.delete();
      step(1, 32'h99, rnd64(), 8'hAA, 1);
      chk("full_pp_count", count, DEPTH);
      chk("full_pp_ovf", overflow_err, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1);
      chk("full_pp_n", drained.size(), DEPTH + 1);
      if (drained.size() > 0) chk("full_pp_last", drained[drained.size()-1], 32'h99);

      // Wrap-around with random drain readiness.
      do_reset();
      pushed.delete(); drained.delete();
      n = 0; guard = 0;
      while (n < 20 && guard < 400) begin
         rdy = 1'($urandom_range(0, 1));
         iv  = (q.size() < DEPTH) || rdy;
         a   = $urandom;
         if (iv) begin
            pushed.push_back(a);
            n++;
         end
         step(iv, a, rnd64(), 8'($urandom), rdy);
         chk("wrap_count_le", count <= DEPTH, 1'b1);
         guard++;
      end
      chk("wrap_pushed", n, 20);
      guard = 0;
      while (q.size() > 0 && guard < 40) begin
         step(0, 0, 0, 0, 1);
         guard++;
      end
      chk("wrap_drained_n", drained.size(), pushed.size());
      for (int i = 0; i < pushed.size() && i < drained.size(); i++)
         chk("wrap_order", drained[i], pushed[i]);
      chk("wrap_ovf", overflow_err, 1'b0);

`ifdef VALU_WB_BYPASS_EN
      // Empty-queue bypass, consumed and stored.
      step(0, 0, 0, 0, 1);
      step(1, 32'h77, 64'hDEADBEEFCAFEF00D, 8'h3C, 1);
      chk("byp_take_count", count, 0);
      step(1, 32'h78, 64'h0123456789ABCDEF, 8'hC3, 0);
      chk("byp_store_count", count, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
